// File: rtl/a2d_rr_intf.sv
// a2d_rr_intf
//   Round-robin conversion sequencer for the external 8-channel 12-bit SPI A2D.
//   A free-running timer starts one conversion every 2^TMR_W clocks. Each
//   conversion uses two SPI transactions. The first one addresses the channel.
//   The second one repeats the address and returns the sample in resp[11:0].
//   The round-robin index walks ch0 (batt), ch1 (curr), ch3 (brake), ch4 (torque).
//
// Ports
//   clk, rst_n  clock, async active-low reset
//   done        1-cycle pulse from the SPI monarch at the end of a transaction
//   resp[15:0]  SPI response, valid while done=1
//   snd         1-cycle request to the monarch to start a transaction
//   cmd[15:0]   command word {2'b00, chnl[2:0], 11'h000}
//   batt/curr/brake/torque[11:0]  latest readings
//   cnv_cmplt   1-cycle pulse when a reading register has just been written
module a2d_rr_intf #(
  parameter int TMR_W = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

  // snd is a flop. It is set on the edge that enters the cycle where it must be
  // seen. So IDLE decodes "timer about to become all-ones" so that snd is high
  // in the cycle where tmr is all-ones.
  localparam logic [TMR_W-1:0] TMR_PRE = {{(TMR_W-1){1'b1}}, 1'b0};

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       rr;
  logic             snd_nxt;
  logic             cnv_nxt;
  logic [2:0]       chnl;
  logic [3:0][11:0] rd;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmr <= '0;
    else        tmr <= tmr + 1'b1;

  always_comb begin
    case (rr)
      2'd0:    chnl = 3'd0;
      2'd1:    chnl = 3'd1;
      2'd2:    chnl = 3'd3;
      default: chnl = 3'd4;
    endcase
  end

  assign cmd = {2'b00, chnl, 11'h000};

  always_comb begin
    state_nxt = state;
    snd_nxt   = 1'b0;
    cnv_nxt   = 1'b0;
    case (state)
      IDLE: if (tmr == TMR_PRE) begin
        state_nxt = CMD;
        snd_nxt   = 1'b1;
      end
      // The first response only carries the previous sample and is dropped.
      // Re-request from GAP: the monarch is idle for that one cycle.
      CMD: if (done) begin
        state_nxt = GAP;
        snd_nxt   = 1'b1;
      end
      GAP: state_nxt = READ;
      READ: if (done) begin
        state_nxt = IDLE;
        cnv_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      snd       <= 1'b0;
      cnv_cmplt <= 1'b0;
      rr        <= 2'd0;
      rd        <= '0;
    end else begin
      state     <= state_nxt;
      snd       <= snd_nxt;
      cnv_cmplt <= cnv_nxt;
      if (cnv_nxt) begin
        rd[rr] <= resp[11:0];
        rr     <= rr + 2'd1;
      end
    end

  assign batt   = rd[0];
  assign curr   = rd[1];
  assign brake  = rd[2];
  assign torque = rd[3];

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Testbench for a2d_rr_intf (TMR_W=11, period 2048 clocks). It uses an SPI
// monarch stand-in with programmable done latency, and a reference model made
// of reading registers, a conversion index, and expected start cycles.
module tb_a2d_rr_intf;
  localparam int TMR_W = 11;
  localparam int PER   = 1 << TMR_W;

  logic        clk = 0;
  logic        rst_n;
  logic        done;
  logic [15:0] resp;
  logic        snd;
  logic [15:0] cmd;
  logic [11:0] batt, curr, brake, torque;
  logic        cnv_cmplt;

  a2d_rr_intf #(.TMR_W(TMR_W)) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .resp(resp), .snd(snd), .cmd(cmd),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque), .cnv_cmplt(cnv_cmplt)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the DUT timer should equal cyc mod PER.
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          chmap [4] = '{0, 1, 3, 4};
  logic [11:0] rd_m  [4];
  int          rr_m;
  int          next_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cmd();
    int ch;
    ch = chmap[rr_m];
    return 16'(ch << 11);
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_batt"},   {20'h0, batt},   {20'h0, rd_m[0]});
    chk({tag, "_curr"},   {20'h0, curr},   {20'h0, rd_m[1]});
    chk({tag, "_brake"},  {20'h0, brake},  {20'h0, rd_m[2]});
    chk({tag, "_torque"}, {20'h0, torque}, {20'h0, rd_m[3]});
  endtask

  // Waits (bounded) for snd and checks that it starts at the predicted cycle.
  task automatic wait_snd(output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (snd === 1'b1) begin ok = 1; break; end
      n++;
    end
    chk("snd_timeout", {31'h0, ok}, 32'h1);
    if (ok) begin
      chk("snd_start_cycle", cyc, next_start);
      chk("snd_cmd", {16'h0, cmd}, {16'h0, exp_cmd()});
    end
  endtask

  // Runs one full conversion with done latencies d1/d2 after each snd.
  task automatic conv(input int d1, input int d2, input logic [15:0] r2, input bit spur_gap);
    bit ok;
    int c;
    wait_snd(ok);
    if (!ok) return;
    for (int i = 0; i < d1; i++) begin
      @(negedge clk);
      if (snd !== 1'b0) chk("no_snd_cmd_phase", {31'h0, snd}, 32'h0);
    end
    done = 1; resp = 16'($urandom);
    @(negedge clk);
    // GAP cycle: second snd must be up now
    done = spur_gap; resp = 16'($urandom);
    chk("snd2_after_done", {31'h0, snd}, 32'h1);
    chk("snd2_cmd", {16'h0, cmd}, {16'h0, exp_cmd()});
    if (spur_gap) begin
      @(negedge clk);
      done = 0;
      chk("gap_spur_cnv", {31'h0, cnv_cmplt}, 32'h0);
      chk("gap_spur_snd", {31'h0, snd}, 32'h0);
    end
    for (int i = 0; i < d2; i++) begin
      @(negedge clk);
      if (snd !== 1'b0)       chk("no_snd_read_phase", {31'h0, snd}, 32'h0);
      if (cnv_cmplt !== 1'b0) chk("no_cnv_read_phase", {31'h0, cnv_cmplt}, 32'h0);
    end
    done = 1; resp = r2;
    @(negedge clk);
    done = 0;
    rd_m[rr_m] = r2[11:0];
    rr_m = (rr_m + 1) % 4;
    chk("cnv_cmplt_hi", {31'h0, cnv_cmplt}, 32'h1);
    chk_regs("conv");
    // Next start: first cycle after returning to IDLE whose timer is all-ones.
    c = cyc + 1;
    while (c % PER != PER - 1) c++;
    next_start = c;
    @(negedge clk);
    chk("cnv_cmplt_lo", {31'h0, cnv_cmplt}, 32'h0);
  endtask

  initial begin
    bit ok;
    logic [11:0] up;
    rst_n = 0; done = 0; resp = '0;
    for (int i = 0; i < 4; i++) rd_m[i] = '0;
    rr_m = 0;
    next_start = PER - 1;

    repeat (3) @(negedge clk);
    chk("rst_snd", {31'h0, snd}, 32'h0);
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_cnv", {31'h0, cnv_cmplt}, 32'h0);
    chk_regs("rst");
    rst_n = 1;

    // First conversion with the fixed FABC response: only batt moves.
    conv(600, 600, 16'hFABC, 0);

    // Full rotation: channel*0x111 with junk in the ignored upper nibble.
    for (int k = 0; k < 5; k++) begin
      up = 12'(chmap[rr_m] * 12'h111);
      conv($urandom_range(300, 700), $urandom_range(300, 700),
           {4'($urandom), up}, 0);
    end

    // Spurious done while idle.
    repeat (20) @(negedge clk);
    done = 1; resp = 16'($urandom);
    @(negedge clk);
    done = 0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_spur_cnv", {31'h0, cnv_cmplt}, 32'h0);
    end
    chk_regs("idle_spur");

    // Spurious done in GAP, random data.
    conv($urandom_range(300, 700), $urandom_range(300, 700), 16'($urandom), 1);

    // Slow slave: conversion spans a timer wrap.
    conv(1500, 1000, 16'($urandom), 0);
    conv($urandom_range(300, 700), $urandom_range(300, 700), 16'($urandom), 0);

    // Reset during READ; the late done must be ignored.
    wait_snd(ok);
    repeat (400) @(negedge clk);
    done = 1; resp = 16'($urandom);
    @(negedge clk);
    done = 0;
    chk("rstmid_snd2", {31'h0, snd}, 32'h1);
    repeat (100) @(negedge clk);
    rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) rd_m[i] = '0;
    rr_m = 0;
    chk("rstmid_snd", {31'h0, snd}, 32'h0);
    chk("rstmid_cmd", {16'h0, cmd}, 32'h0);
    chk("rstmid_cnv", {31'h0, cnv_cmplt}, 32'h0);
    chk_regs("rstmid");
    @(negedge clk);
    rst_n = 1;
    repeat (200) @(negedge clk);
    done = 1; resp = 16'h0FFF;
    @(negedge clk);
    done = 0;
    chk("late_done_cnv", {31'h0, cnv_cmplt}, 32'h0);
    @(negedge clk);
    chk_regs("late_done");
    next_start = PER - 1;
    conv($urandom_range(300, 700), $urandom_range(300, 700), 16'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
